// File: rtl/ext_dbus_pkg.sv
// Shared definitions for the external data-bus controller: FSM states,
// pad drive encodings and legal parameter ranges.
package ext_dbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TURN    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RWAIT   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Per-bit pad encoding as {n_drv_high, drv_low}. The combination 2'b01
  // (pull-up and pull-down both on) is deliberately unreachable.
  localparam logic [1:0] PAD_DRV1  = 2'b00;
  localparam logic [1:0] PAD_DRV0  = 2'b11;
  localparam logic [1:0] PAD_FLOAT = 2'b10;

  localparam int TURN_MIN    = 1;
  localparam int TURN_MAX    = 15;
  localparam int HOLD_MIN    = 1;
  localparam int HOLD_MAX    = 15;
  localparam int RD_WAIT_MIN = 2;
  localparam int RD_WAIT_MAX = 15;

  // Encode one pad bit: drive its data value, or float.
  function automatic logic [1:0] pad_enc(input logic drive, input logic val);
    if (!drive) return PAD_FLOAT;
    return val ? PAD_DRV1 : PAD_DRV0;
  endfunction

endpackage

// File: rtl/ext_dbus_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous pad input levels.
module dbus_sync #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         n_RESET,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second settles.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ext_dbus_ctrl.sv
// External 8-bit bidirectional data-bus controller. Writes float the bus for
// a turnaround, drive latched data, then release; reads float the bus, wait,
// and capture the synchronized (inverted) pad levels.
// Optional feature: define EXT_DBUS_KEEPER_EN to enable weak pull-ups while
// the bus is not being driven by this block.
module ext_dbus_ctrl
  import ext_dbus_pkg::*;
#(
  parameter int TURN    = 1,
  parameter int HOLD    = 2,
  parameter int RD_WAIT = 3
) (
  input  logic       CLK,
  input  logic       n_RESET,
  input  logic       REQ,
  input  logic       WR,
  input  logic [7:0] WDATA,
  output logic       ACK,
  output logic [7:0] RDATA,
  output logic [7:0] DRV_LOW,
  output logic [7:0] n_DRV_HIGH,
  output logic [7:0] n_ENA_PU,
  input  logic [7:0] n_INPUT
);

  if (TURN < TURN_MIN || TURN > TURN_MAX ||
      HOLD < HOLD_MIN || HOLD > HOLD_MAX ||
      RD_WAIT < RD_WAIT_MIN || RD_WAIT > RD_WAIT_MAX) begin : g_param_err
    $error("ext_dbus_ctrl: TURN/HOLD/RD_WAIT out of legal range");
  end

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] wdata_q;
  logic [7:0] sync_q;

  dbus_sync #(.W(8)) u_sync (
    .CLK     (CLK),
    .n_RESET (n_RESET),
    .d       (n_INPUT),
    .q       (sync_q)
  );

  // Next-state and shared down-counter; the counter is loaded with (N-1) on
  // entry so each timed state lasts exactly N cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: if (REQ) begin
        state_nxt = WR ? ST_TURN : ST_RWAIT;
        cnt_nxt   = WR ? 4'(TURN - 1) : 4'(RD_WAIT - 1);
      end
      ST_TURN: if (cnt == 4'd0) begin
        state_nxt = ST_DRIVE;
        cnt_nxt   = 4'(HOLD - 1);
      end else cnt_nxt = cnt - 4'd1;
      ST_DRIVE: if (cnt == 4'd0) state_nxt = ST_RELEASE;
                else cnt_nxt = cnt - 4'd1;
      ST_RELEASE: state_nxt = ST_IDLE;
      ST_RWAIT: if (cnt == 4'd0) state_nxt = ST_DONE;
                else cnt_nxt = cnt - 4'd1;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter, write-data latch and read capture register.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      wdata_q <= 8'h00;
      RDATA   <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && REQ && WR) wdata_q <= WDATA;
      if (state == ST_RWAIT && cnt == 4'd0) RDATA <= ~sync_q;
    end
  end

  // Pad drivers decode straight from state, so reset floats them at once.
  always_comb begin
    n_DRV_HIGH = 8'hFF;
    DRV_LOW    = 8'h00;
    for (int i = 0; i < 8; i++)
      {n_DRV_HIGH[i], DRV_LOW[i]} = pad_enc(state == ST_DRIVE, wdata_q[i]);
  end

  assign ACK = (state == ST_RELEASE) || (state == ST_DONE);

`ifdef EXT_DBUS_KEEPER_EN
  // Keepers on whenever this block is not (about to be) driving the bus.
  assign n_ENA_PU = (state == ST_IDLE || state == ST_RWAIT || state == ST_DONE)
                    ? 8'h00 : 8'hFF;
`else
  assign n_ENA_PU = 8'hFF;
`endif

endmodule

// File: tb/tb_ext_dbus_ctrl.sv
// Directed table-driven bench for ext_dbus_ctrl plus reset and random runs.
module tb_ext_dbus_ctrl;

  logic       CLK = 1'b0;
  logic       n_RESET = 1'b0;
  logic       REQ = 1'b0;
  logic       WR = 1'b0;
  logic [7:0] WDATA = 8'h00;
  logic [7:0] n_INPUT = 8'hC3;
  logic       ACK;
  logic [7:0] RDATA, DRV_LOW, n_DRV_HIGH, n_ENA_PU;

  ext_dbus_ctrl dut (
    .CLK(CLK), .n_RESET(n_RESET), .REQ(REQ), .WR(WR), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .DRV_LOW(DRV_LOW), .n_DRV_HIGH(n_DRV_HIGH),
    .n_ENA_PU(n_ENA_PU), .n_INPUT(n_INPUT)
  );

  always #5 CLK = ~CLK;

`ifdef EXT_DBUS_KEEPER_EN
  localparam bit KEEPER = 1'b1;
`else
  localparam bit KEEPER = 1'b0;
`endif
  localparam int WLEN = 1 + 2 + 1;  // TURN + HOLD + RELEASE
  localparam int RLEN = 3 + 1;      // RD_WAIT + DONE

  int checks = 0;
  int failures = 0;
  int viol = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Contention monitor: pull-up on and pull-down on for the same bit.
  always @(negedge CLK)
    if (|(~n_DRV_HIGH & DRV_LOW)) viol++;

  typedef struct {
    logic       req, wr;
    logic [7:0] wdata, nin;
    logic       ack;
    logic [7:0] dl, ndh, rd;
    logic       kp;
  } vec_t;

  vec_t v[27];

  function automatic vec_t mk(input logic req, input logic wr, input logic [7:0] wdata,
                              input logic [7:0] nin, input logic ack, input logic [7:0] dl,
                              input logic [7:0] ndh, input logic [7:0] rd, input logic kp);
    vec_t r;
    r.req = req; r.wr = wr; r.wdata = wdata; r.nin = nin;
    r.ack = ack; r.dl = dl; r.ndh = ndh; r.rd = rd; r.kp = kp;
    return r;
  endfunction

  initial begin
    logic [7:0] pu_exp;
    logic       m_busy, exp_ack;
    int         m_cnt, acks, accepts, nprint;

    // Each row: inputs driven in this cycle / outputs expected in this cycle.
    // Write A5: float, drive A5 x2 (pads 5A/5A), release+ACK.
    v[0]  = mk(1,1,8'hA5,8'hC3, 0,8'h00,8'hFF,8'h00,1);
    v[1]  = mk(0,0,8'h00,8'hC3, 0,8'h00,8'hFF,8'h00,0);
    v[2]  = mk(0,0,8'h00,8'hC3, 0,8'h5A,8'h5A,8'h00,0);
    v[3]  = mk(0,0,8'h00,8'hC3, 0,8'h5A,8'h5A,8'h00,0);
    v[4]  = mk(0,0,8'h00,8'hC3, 1,8'h00,8'hFF,8'h00,0);
    // Read with n_INPUT=C3 -> RDATA 3C in DONE; REQ held into next IDLE.
    v[5]  = mk(1,0,8'h00,8'hC3, 0,8'h00,8'hFF,8'h00,1);
    v[6]  = mk(0,0,8'h00,8'hC3, 0,8'h00,8'hFF,8'h00,1);
    v[7]  = mk(0,0,8'h00,8'hC3, 0,8'h00,8'hFF,8'h00,1);
    v[8]  = mk(0,0,8'h00,8'hC3, 0,8'h00,8'hFF,8'h00,1);
    v[9]  = mk(1,1,8'h00,8'hC3, 1,8'h00,8'hFF,8'h3C,1);
    // Write 00 accepted one cycle after ACK; mid-transaction inputs ignored.
    v[10] = mk(1,1,8'h00,8'hC3, 0,8'h00,8'hFF,8'h3C,1);
    v[11] = mk(1,0,8'h77,8'h5A, 0,8'h00,8'hFF,8'h3C,0);
    v[12] = mk(0,1,8'hFF,8'h5A, 0,8'hFF,8'hFF,8'h3C,0);
    v[13] = mk(1,0,8'h11,8'h5A, 0,8'hFF,8'hFF,8'h3C,0);
    v[14] = mk(1,0,8'h00,8'h5A, 1,8'h00,8'hFF,8'h3C,0);
    // Read accepted with REQ still held; RDATA becomes ~5A = A5.
    v[15] = mk(1,0,8'h00,8'h5A, 0,8'h00,8'hFF,8'h3C,1);
    v[16] = mk(0,1,8'hAA,8'h5A, 0,8'h00,8'hFF,8'h3C,1);
    v[17] = mk(1,1,8'hBB,8'h5A, 0,8'h00,8'hFF,8'h3C,1);
    v[18] = mk(0,0,8'hCC,8'h5A, 0,8'h00,8'hFF,8'h3C,1);
    v[19] = mk(0,0,8'h00,8'h5A, 1,8'h00,8'hFF,8'hA5,1);
    // Undriven bus (pads all high, n_INPUT=00) -> RDATA FF.
    v[20] = mk(0,0,8'h00,8'h00, 0,8'h00,8'hFF,8'hA5,1);
    v[21] = mk(1,0,8'h00,8'h00, 0,8'h00,8'hFF,8'hA5,1);
    v[22] = mk(0,0,8'h00,8'h00, 0,8'h00,8'hFF,8'hA5,1);
    v[23] = mk(0,0,8'h00,8'h00, 0,8'h00,8'hFF,8'hA5,1);
    v[24] = mk(0,0,8'h00,8'h00, 0,8'h00,8'hFF,8'hA5,1);
    v[25] = mk(0,0,8'h00,8'h00, 1,8'h00,8'hFF,8'hFF,1);
    v[26] = mk(0,0,8'h00,8'h00, 0,8'h00,8'hFF,8'hFF,1);

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst ack", {7'd0, ACK}, 8'h00);
    chk("rst rdata", RDATA, 8'h00);
    chk("rst drv_low", DRV_LOW, 8'h00);
    chk("rst n_drv_high", n_DRV_HIGH, 8'hFF);
    chk("rst n_ena_pu", n_ENA_PU, 8'hFF);
    n_RESET = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge CLK);
      pu_exp = (KEEPER && v[i].kp) ? 8'h00 : 8'hFF;
      chk($sformatf("v%0d ack", i), {7'd0, ACK}, {7'd0, v[i].ack});
      chk($sformatf("v%0d drv_low", i), DRV_LOW, v[i].dl);
      chk($sformatf("v%0d n_drv_high", i), n_DRV_HIGH, v[i].ndh);
      chk($sformatf("v%0d rdata", i), RDATA, v[i].rd);
      chk($sformatf("v%0d n_ena_pu", i), n_ENA_PU, pu_exp);
      REQ = v[i].req; WR = v[i].wr; WDATA = v[i].wdata; n_INPUT = v[i].nin;
    end

    // Reset asserted in the second DRIVE cycle.
    @(negedge CLK); REQ = 1'b1; WR = 1'b1; WDATA = 8'hA5;
    @(negedge CLK); REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rstdrv pre drv_low", DRV_LOW, 8'h5A);
    #2 n_RESET = 1'b0;
    #1;
    chk("rstdrv drv_low", DRV_LOW, 8'h00);
    chk("rstdrv n_drv_high", n_DRV_HIGH, 8'hFF);
    chk("rstdrv ack", {7'd0, ACK}, 8'h00);
    chk("rstdrv rdata", RDATA, 8'h00);
    @(negedge CLK); n_RESET = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("postrst%0d ack", i), {7'd0, ACK}, 8'h00);
      chk($sformatf("postrst%0d drv_low", i), DRV_LOW, 8'h00);
      chk($sformatf("postrst%0d n_drv_high", i), n_DRV_HIGH, 8'hFF);
    end
    chk("postrst rdata", RDATA, 8'h00);

    // Random traffic with a transaction-length ACK model.
    m_busy = 1'b0; m_cnt = 0; acks = 0; accepts = 0; nprint = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      if (m_busy) m_cnt--;
      exp_ack = m_busy && (m_cnt == 0);
      checks++;
      if (ACK !== exp_ack) begin
        failures++;
        if (nprint < 10) $display("FAIL rnd ack cycle %0d: got %b expected %b", c, ACK, exp_ack);
        nprint++;
      end
      if (ACK === 1'b1) acks++;
      if (exp_ack) m_busy = 1'b0;
      REQ     = (c < 9990) ? 1'($urandom_range(0, 1)) : 1'b0;
      WR      = 1'($urandom_range(0, 1));
      WDATA   = 8'($urandom);
      n_INPUT = 8'($urandom);
      if (!m_busy && !exp_ack && REQ) begin
        m_busy = 1'b1;
        m_cnt  = WR ? WLEN : RLEN;
        accepts++;
      end
    end
    checks++;
    if (acks != accepts || accepts == 0) begin
      failures++;
      $display("FAIL rnd ack count: got %0d expected %0d", acks, accepts);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL pad contention: got %0d expected 0", viol);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
